// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit with x86-style OF/CF/SF/ZF flags.
// The carry chain is split into STAGES slices, with one slice resolved per register stage.
module addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             of,
    output logic             cf,
    output logic             sf,
    output logic             zf
);

    localparam int SW  = WIDTH / STAGES;
    localparam int MSB = WIDTH - 1;
    localparam int FIN = STAGES - 1;

    logic [WIDTH-1:0]  a_r    [STAGES];
    logic [WIDTH-1:0]  be_r   [STAGES];
    logic [WIDTH-1:0]  sum_r  [STAGES];
    logic [STAGES-1:0] zero_r [STAGES];
    logic              cy_r   [STAGES];
    logic              sub_r  [STAGES];
    logic              v_r    [STAGES];
    logic              of_r, cf_r, sf_r, zf_r;

    logic [WIDTH-1:0]  st_a_s    [STAGES];
    logic [WIDTH-1:0]  st_be_s   [STAGES];
    logic [WIDTH-1:0]  st_sum_s  [STAGES];
    logic [STAGES-1:0] st_zero_s [STAGES];
    logic              st_cy_s   [STAGES];
    logic              st_sub_s  [STAGES];
    logic              st_v_s    [STAGES];
    logic [SW:0]       slice_s   [STAGES];
    logic [WIDTH-1:0]  nx_sum_s  [STAGES];
    logic [STAGES-1:0] nx_zero_s [STAGES];

    logic adv_s;
    logic cin0_s;
    logic of_s, cf_s, sf_s, zf_s;

    assign adv_s = !v_r[FIN] || out_ready;

    // Carry into slice 0; subtraction is a + ~b + 1, and SBB borrows by dropping that +1.
    always_comb begin
        cin0_s = 1'b0;
        case (op)
            2'b00:   cin0_s = 1'b0;
            2'b01:   cin0_s = 1'b1;
            2'b10:   cin0_s = cin;
            2'b11:   cin0_s = ~cin;
            default: cin0_s = 1'b0;
        endcase
    end

    genvar g;
    for (g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign st_a_s[g]    = a;
            assign st_be_s[g]   = op[0] ? ~b : b;
            assign st_sum_s[g]  = {WIDTH{1'b0}};
            assign st_zero_s[g] = {STAGES{1'b0}};
            assign st_cy_s[g]   = cin0_s;
            assign st_sub_s[g]  = op[0];
            assign st_v_s[g]    = in_valid;
        end else begin : g_body
            assign st_a_s[g]    = a_r[g-1];
            assign st_be_s[g]   = be_r[g-1];
            assign st_sum_s[g]  = sum_r[g-1];
            assign st_zero_s[g] = zero_r[g-1];
            assign st_cy_s[g]   = cy_r[g-1];
            assign st_sub_s[g]  = sub_r[g-1];
            assign st_v_s[g]    = v_r[g-1];
        end

        // Resolve this stage's slice and merge it into the partial sum and zero mask.
        always_comb begin
            slice_s[g] = {1'b0, st_a_s[g][g*SW +: SW]} + {1'b0, st_be_s[g][g*SW +: SW]}
                       + {{SW{1'b0}}, st_cy_s[g]};
            nx_sum_s[g]              = st_sum_s[g];
            nx_sum_s[g][g*SW +: SW]  = slice_s[g][SW-1:0];
            nx_zero_s[g]             = st_zero_s[g];
            nx_zero_s[g][g]          = (slice_s[g][SW-1:0] == {SW{1'b0}});
        end
    end

    // Flags from the last slice; CF becomes a borrow for subtract-type ops.
    always_comb begin
        cf_s = slice_s[FIN][SW] ^ st_sub_s[FIN];
        sf_s = nx_sum_s[FIN][MSB];
        zf_s = &nx_zero_s[FIN];
        of_s = (st_a_s[FIN][MSB] == st_be_s[FIN][MSB]) && (nx_sum_s[FIN][MSB] != st_a_s[FIN][MSB]);
    end

    // Pipeline registers: the whole pipe moves together or freezes together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]    <= {WIDTH{1'b0}};
                be_r[k]   <= {WIDTH{1'b0}};
                sum_r[k]  <= {WIDTH{1'b0}};
                zero_r[k] <= {STAGES{1'b0}};
                cy_r[k]   <= 1'b0;
                sub_r[k]  <= 1'b0;
                v_r[k]    <= 1'b0;
            end
            of_r <= 1'b0;
            cf_r <= 1'b0;
            sf_r <= 1'b0;
            zf_r <= 1'b0;
        end else if (adv_s) begin
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]    <= st_a_s[k];
                be_r[k]   <= st_be_s[k];
                sum_r[k]  <= nx_sum_s[k];
                zero_r[k] <= nx_zero_s[k];
                cy_r[k]   <= slice_s[k][SW];
                sub_r[k]  <= st_sub_s[k];
                v_r[k]    <= st_v_s[k];
            end
            of_r <= of_s;
            cf_r <= cf_s;
            sf_r <= sf_s;
            zf_r <= zf_s;
        end
    end

    assign in_ready  = adv_s;
    assign out_valid = v_r[FIN];
    assign c         = sum_r[FIN];
    assign of        = of_r;
    assign cf        = cf_r;
    assign sf        = sf_r;
    assign zf        = zf_r;

endmodule
